cam_sccb_config: RTL

- Power-up configuration sequencer for the OV7670 camera feeding the cam_read / buffer_ram_dp / VGA_Driver path.
- Walks an external register table of {reg_addr, reg_value} words and issues one SCCB 3-phase write per entry: device ID, register, value.
- Supports an inline delay marker (post soft-reset wait) and an end marker, then reports done.
- Runs on clk25M in test_cam; SIOC/SIOD go to the camera pins, with the SIOD tristate buffer at top level.

---
 rtl/cam_sccb_config.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cam_sccb_config.sv
// OV7670 power-up sequencer: walks a {reg, value} table and issues one SCCB
// 3-phase write per entry, with inline delay and end markers.
module cam_sccb_config #(
   parameter int unsigned CLK_DIV      = 62,
   parameter logic [7:0]  DEV_ID       = 8'h42,
   parameter int unsigned DELAY_CYCLES = 250000,
   parameter int unsigned ROM_AW       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              sioc,
   output logic              siod_o,
   output logic              siod_oe,
   output logic              busy,
   output logic              done
);
   localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam int unsigned FW = 27;
   localparam int unsigned BW = 5;
   localparam logic [15:0] MARK_END = 16'hFFFF;
   localparam logic [15:0] MARK_DLY = 16'hFFF0;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
   } state_t;

   state_t          state, state_d;
   logic [QW-1:0]   qcnt, qcnt_d;
   logic [1:0]      qidx, qidx_d;
   logic [BW-1:0]   bcnt, bcnt_d;
   logic [FW-1:0]   sreg, sreg_d;
   logic [DW-1:0]   dcnt, dcnt_d;
   logic [ROM_AW-1:0] addr_d;
   logic            sioc_d, siod_d, oe_d, busy_d, done_d;
   logic            tick, advance, ack;

   // Next-state logic; pin values are derived from the next state so they
   // toggle on the same edge the quarter index advances.
   always_comb begin
      state_d = state;
      qcnt_d  = '0;
      qidx_d  = qidx;
      bcnt_d  = bcnt;
      sreg_d  = sreg;
      dcnt_d  = '0;
      addr_d  = rom_addr;
      advance = 1'b0;
      tick    = (qcnt == QW'(CLK_DIV - 1));

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FETCH;
               addr_d  = '0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (rom_data == MARK_END) begin
               state_d = S_DONE;
            end else if (rom_data == MARK_DLY) begin
               state_d = S_DELAY;
            end else begin
               sreg_d  = {DEV_ID, 1'b0, rom_data[15:8], 1'b0, rom_data[7:0], 1'b0};
               qidx_d  = '0;
               bcnt_d  = '0;
               state_d = S_START;
            end
         end
         S_START, S_BITS, S_STOP, S_GAP: begin
            qcnt_d = tick ? '0 : qcnt + QW'(1);
            if (tick) begin
               qidx_d = qidx + 2'd1;
               if (qidx == 2'd3) begin
                  case (state)
                     S_START: state_d = S_BITS;
                     S_BITS: begin
                        sreg_d = {sreg[FW-2:0], 1'b0};
                        bcnt_d = bcnt + BW'(1);
                        if (bcnt == BW'(FW - 1)) state_d = S_STOP;
                     end
                     S_STOP:  state_d = S_GAP;
                     default: advance = 1'b1;
                  endcase
               end
            end
         end
         S_DELAY: begin
            if (dcnt == DW'(DELAY_CYCLES - 1)) advance = 1'b1;
            else dcnt_d = dcnt + DW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // Last table slot ends the walk even without an end marker
      if (advance) begin
         if (rom_addr == '1) begin
            state_d = S_DONE;
         end else begin
            addr_d  = rom_addr + ROM_AW'(1);
            state_d = S_FETCH;
         end
      end

      ack    = (bcnt_d == BW'(8)) || (bcnt_d == BW'(17)) || (bcnt_d == BW'(26));
      sioc_d = 1'b1;
      siod_d = 1'b1;
      oe_d   = 1'b1;
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
      case (state_d)
         S_START: begin
            sioc_d = (qidx_d != 2'd3);
            siod_d = (qidx_d == 2'd0);
         end
         S_BITS: begin
            sioc_d = qidx_d[1];
            siod_d = sreg_d[FW-1];
            oe_d   = ~ack;
         end
         S_STOP: begin
            sioc_d = (qidx_d != 2'd0);
            siod_d = qidx_d[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         qcnt     <= '0;
         qidx     <= '0;
         bcnt     <= '0;
         sreg     <= '0;
         dcnt     <= '0;
         rom_addr <= '0;
         sioc     <= 1'b1;
         siod_o   <= 1'b1;
         siod_oe  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         qcnt     <= qcnt_d;
         qidx     <= qidx_d;
         bcnt     <= bcnt_d;
         sreg     <= sreg_d;
         dcnt     <= dcnt_d;
         rom_addr <= addr_d;
         sioc     <= sioc_d;
         siod_o   <= siod_d;
         siod_oe  <= oe_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end
endmodule
